// File: rtl/sc_backg_sequencer_if.sv
// Control/status bundle between the background-type sequencer and the Frogger datapath.
// The sequencer side uses the master modport; the datapath/game side uses slave.
interface sc_backg_sequencer_if;
    logic       SC_BackgSeq_start_InLow;
    logic       SC_BackgSeq_levelcomplete_InHigh;
    logic       SC_BackgSeq_lose_InHigh;
    logic       SC_BackgSeq_tick_InHigh;
    logic       SC_BackgSeq_clear_OutLow;
    logic       SC_BackgSeq_load_OutLow;
    logic [1:0] SC_BackgSeq_shiftselection_OutBUS;
    logic [3:0] SC_BackgSeq_transitioncounter_OutBUS;
    logic       SC_BackgSeq_busy_OutHigh;

    modport master (
        input  SC_BackgSeq_start_InLow,
        input  SC_BackgSeq_levelcomplete_InHigh,
        input  SC_BackgSeq_lose_InHigh,
        input  SC_BackgSeq_tick_InHigh,
        output SC_BackgSeq_clear_OutLow,
        output SC_BackgSeq_load_OutLow,
        output SC_BackgSeq_shiftselection_OutBUS,
        output SC_BackgSeq_transitioncounter_OutBUS,
        output SC_BackgSeq_busy_OutHigh
    );

    modport slave (
        output SC_BackgSeq_start_InLow,
        output SC_BackgSeq_levelcomplete_InHigh,
        output SC_BackgSeq_lose_InHigh,
        output SC_BackgSeq_tick_InHigh,
        input  SC_BackgSeq_clear_OutLow,
        input  SC_BackgSeq_load_OutLow,
        input  SC_BackgSeq_shiftselection_OutBUS,
        input  SC_BackgSeq_transitioncounter_OutBUS,
        input  SC_BackgSeq_busy_OutHigh
    );
endinterface

// File: rtl/sc_backg_sequencer.sv
// Screen sequencer for the Frogger background-type register: START, transition/level pairs,
// WIN and the losing path. All outputs are registered alongside the state.
module sc_backg_sequencer #(
    parameter int TRANS_TICKS    = 8,
    parameter int TICK_CNT_WIDTH = 4
) (
    input  logic                 SC_RegBACKGTYPE_CLOCK_50,
    input  logic                 SC_RegBACKGTYPE_RESET_InHigh,
    sc_backg_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOAD,
        ST_WAIT_START,
        ST_ANIM,
        ST_PLAY,
        ST_LOSE,
        ST_LOSE_WAIT,
        ST_WIN
    } state_t;

    typedef enum logic [1:0] {
        SHIFT_HOLD  = 2'b00,
        SHIFT_LEFT  = 2'b01,
        SHIFT_RIGHT = 2'b10
    } shift_t;

    localparam logic [3:0]                IDX_START = 4'd0;
    localparam logic [3:0]                IDX_WIN   = 4'd9;
    localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST = TICK_CNT_WIDTH'(TRANS_TICKS);

    logic clk;
    logic rst;
    assign clk = SC_RegBACKGTYPE_CLOCK_50;
    assign rst = SC_RegBACKGTYPE_RESET_InHigh;

    state_t                    state,       state_nxt;
    logic [3:0]                index,       index_nxt;
    logic [TICK_CNT_WIDTH-1:0] tick_cnt,    tick_cnt_nxt;
    logic                      clear_n,     clear_n_nxt;
    logic                      load_n,      load_n_nxt;
    shift_t                    shift,       shift_nxt;
    logic                      busy,        busy_nxt;
    logic                      start_armed, start_armed_nxt;
    logic                      start_evt;

    // A held button counts once: it must be seen released before it can start again.
    assign start_evt = start_armed & ~bus.SC_BackgSeq_start_InLow;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_nxt       = state;
        index_nxt       = index;
        tick_cnt_nxt    = tick_cnt;
        clear_n_nxt     = 1'b1;
        load_n_nxt      = 1'b1;
        shift_nxt       = SHIFT_HOLD;
        busy_nxt        = 1'b0;
        start_armed_nxt = bus.SC_BackgSeq_start_InLow ? 1'b1 : start_armed;

        case (state)
            ST_INIT: begin
                state_nxt  = ST_LOAD;
                index_nxt  = IDX_START;
                load_n_nxt = 1'b0;
            end

            ST_LOAD: begin
                if (index == IDX_START) begin
                    state_nxt = ST_WAIT_START;
                end else if (index == IDX_WIN) begin
                    state_nxt = ST_WIN;
                end else if (index[0]) begin
                    state_nxt    = ST_ANIM;
                    tick_cnt_nxt = '0;
                    busy_nxt     = 1'b1;
                end else begin
                    state_nxt = ST_PLAY;
                end
            end

            ST_WAIT_START: begin
                if (start_evt) begin
                    state_nxt       = ST_LOAD;
                    index_nxt       = 4'd1;
                    load_n_nxt      = 1'b0;
                    start_armed_nxt = 1'b0;
                end
            end

            ST_ANIM: begin
                // The last rotate has already been issued once the count reaches TICK_LAST.
                busy_nxt = 1'b1;
                if (tick_cnt == TICK_LAST) begin
                    state_nxt  = ST_LOAD;
                    index_nxt  = index + 4'd1;
                    load_n_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end else if (bus.SC_BackgSeq_tick_InHigh) begin
                    shift_nxt    = SHIFT_LEFT;
                    tick_cnt_nxt = tick_cnt + 1'b1;
                end
            end

            ST_PLAY: begin
                if (bus.SC_BackgSeq_lose_InHigh) begin
                    state_nxt   = ST_LOSE;
                    clear_n_nxt = 1'b0;
                end else if (bus.SC_BackgSeq_levelcomplete_InHigh) begin
                    state_nxt  = ST_LOAD;
                    index_nxt  = index + 4'd1;
                    load_n_nxt = 1'b0;
                end
            end

            ST_LOSE: begin
                state_nxt = ST_LOSE_WAIT;
            end

            ST_LOSE_WAIT: begin
                if (start_evt) begin
                    state_nxt       = ST_LOAD;
                    index_nxt       = IDX_START;
                    load_n_nxt      = 1'b0;
                    start_armed_nxt = 1'b0;
                end
            end

            ST_WIN: begin
                // Start wins over a coincident tick so load and shift never overlap.
                if (start_evt) begin
                    state_nxt       = ST_LOAD;
                    index_nxt       = IDX_START;
                    load_n_nxt      = 1'b0;
                    start_armed_nxt = 1'b0;
                end else if (bus.SC_BackgSeq_tick_InHigh) begin
                    shift_nxt = SHIFT_RIGHT;
                end
            end

            default: begin
                state_nxt = ST_INIT;
                index_nxt = IDX_START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            index       <= IDX_START;
            tick_cnt    <= '0;
            clear_n     <= 1'b1;
            load_n      <= 1'b1;
            shift       <= SHIFT_HOLD;
            busy        <= 1'b0;
            start_armed <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state       <= state_nxt;
            index       <= index_nxt;
            tick_cnt    <= tick_cnt_nxt;
            clear_n     <= clear_n_nxt;
            load_n      <= load_n_nxt;
            shift       <= shift_nxt;
            busy        <= busy_nxt;
            start_armed <= start_armed_nxt;
        end
    end

    assign bus.SC_BackgSeq_clear_OutLow             = clear_n;
    assign bus.SC_BackgSeq_load_OutLow              = load_n;
    assign bus.SC_BackgSeq_shiftselection_OutBUS    = shift;
    assign bus.SC_BackgSeq_transitioncounter_OutBUS = index;
    assign bus.SC_BackgSeq_busy_OutHigh             = busy;

endmodule

// File: tb/tb_sc_backg_sequencer.sv
// Scenario bench for sc_backg_sequencer: each task walks the screen sequence with randomized
// tick spacing and noise, predicting outputs from the screen rules as {clear,load,shift,counter,busy}.
module tb_sc_backg_sequencer;

    localparam int         TRANS_TICKS = 8;
    localparam logic [1:0] SH_HOLD     = 2'b00;
    localparam logic [1:0] SH_LEFT     = 2'b01;
    localparam logic [1:0] SH_RIGHT    = 2'b10;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    sc_backg_sequencer_if bus ();

    sc_backg_sequencer dut (
        .SC_RegBACKGTYPE_CLOCK_50    (clk),
        .SC_RegBACKGTYPE_RESET_InHigh(rst),
        .bus                         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] obs();
        return {bus.SC_BackgSeq_clear_OutLow, bus.SC_BackgSeq_load_OutLow,
                bus.SC_BackgSeq_shiftselection_OutBUS,
                bus.SC_BackgSeq_transitioncounter_OutBUS, bus.SC_BackgSeq_busy_OutHigh};
    endfunction

    function automatic logic [8:0] ev(input logic c, input logic l, input logic [1:0] s,
                                      input logic [3:0] i, input logic b);
        return {c, l, s, i, b};
    endfunction

    // Apply inputs, let one rising edge sample them, then settle 1 time unit past the edge.
    task automatic drive(input logic s_n, input logic lc, input logic lo, input logic tk);
        bus.SC_BackgSeq_start_InLow          = s_n;
        bus.SC_BackgSeq_levelcomplete_InHigh = lc;
        bus.SC_BackgSeq_lose_InHigh          = lo;
        bus.SC_BackgSeq_tick_InHigh          = tk;
        @(posedge clk);
        #1;
    endtask

    // Precondition: LOAD of odd screen idx just observed. Ends having observed LOAD of idx+1.
    task automatic run_anim(input logic [3:0] idx);
        logic [8:0] want;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, idx, 1'b1);
        if (obs() !== want) begin bad++; $display("FAIL anim_enter idx=%0d cyc=%0d got=%b want=%b", idx, cyc, obs(), want); end
        total++;
        for (int k = 0; k < TRANS_TICKS; k++) begin
            int gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                // start, levelcomplete and lose must all be ignored while animating
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                want = ev(1'b1, 1'b1, SH_HOLD, idx, 1'b1);
                if (obs() !== want) begin bad++; $display("FAIL anim_idle idx=%0d tick=%0d cyc=%0d got=%b want=%b", idx, k, cyc, obs(), want); end
                total++;
            end
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            want = ev(1'b1, 1'b1, SH_LEFT, idx, 1'b1);
            if (obs() !== want) begin bad++; $display("FAIL anim_rotate idx=%0d tick=%0d cyc=%0d got=%b want=%b", idx, k, cyc, obs(), want); end
            total++;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, idx + 4'd1, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL anim_exit idx=%0d cyc=%0d got=%b want=%b", idx, cyc, obs(), want); end
        total++;
    endtask

    // Precondition: LOAD of level screen idx just observed. Ends having observed LOAD of idx+1.
    task automatic play_then_complete(input logic [3:0] idx);
        logic [8:0] want;
        int         linger;
        linger = $urandom_range(1, 4);
        for (int g = 0; g < linger; g++) begin
            drive(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            want = ev(1'b1, 1'b1, SH_HOLD, idx, 1'b0);
            if (obs() !== want) begin bad++; $display("FAIL play_idle idx=%0d cyc=%0d got=%b want=%b", idx, cyc, obs(), want); end
            total++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, idx + 4'd1, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL play_complete idx=%0d cyc=%0d got=%b want=%b", idx, cyc, obs(), want); end
        total++;
    endtask

    task automatic test_reset();
        logic [8:0] want;
        int         idle;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            want = ev(1'b1, 1'b1, SH_HOLD, 4'd0, 1'b0);
            if (obs() !== want) begin bad++; $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, obs(), want); end
            total++;
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd0, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL reset_first_load cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        idle = $urandom_range(3, 6);
        for (int k = 0; k < idle; k++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            want = ev(1'b1, 1'b1, SH_HOLD, 4'd0, 1'b0);
            if (obs() !== want) begin bad++; $display("FAIL wait_start_idle cyc=%0d got=%b want=%b", cyc, obs(), want); end
            total++;
        end
    endtask

    task automatic test_anim();
        logic [8:0] want;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd1, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL start_load cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        run_anim(4'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd2, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL level1_enter cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
    endtask

    task automatic test_lose_priority();
        logic [8:0] want;
        int         idle;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd3, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL level1_complete cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        run_anim(4'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd4, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL level2_enter cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        want = ev(1'b0, 1'b1, SH_HOLD, 4'd4, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL lose_priority_clear cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        idle = $urandom_range(2, 5);
        for (int k = 0; k < idle; k++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            want = ev(1'b1, 1'b1, SH_HOLD, 4'd4, 1'b0);
            if (obs() !== want) begin bad++; $display("FAIL lose_wait_idle cyc=%0d got=%b want=%b", cyc, obs(), want); end
            total++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd0, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL lose_restart_load cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd0, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL lose_restart_wait cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
    endtask

    task automatic test_win_path();
        logic [8:0] want;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd1, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL win_path_start cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        for (int lvl = 1; lvl <= 4; lvl++) begin
            run_anim(4'(2 * lvl - 1));
            play_then_complete(4'(2 * lvl));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd9, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL win_enter cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        for (int k = 0; k < 6; k++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                want = ev(1'b1, 1'b1, SH_HOLD, 4'd9, 1'b0);
                if (obs() !== want) begin bad++; $display("FAIL win_idle cyc=%0d got=%b want=%b", cyc, obs(), want); end
                total++;
            end
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            want = ev(1'b1, 1'b1, SH_RIGHT, 4'd9, 1'b0);
            if (obs() !== want) begin bad++; $display("FAIL win_rotate k=%0d cyc=%0d got=%b want=%b", k, cyc, obs(), want); end
            total++;
        end
    endtask

    task automatic test_start_held();
        logic [8:0] want;
        int         hold;
        // start together with a tick: the tick is dropped, only the reload happens
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd0, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL win_restart_load cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        hold = $urandom_range(3, 8);
        for (int k = 0; k < hold; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            want = ev(1'b1, 1'b1, SH_HOLD, 4'd0, 1'b0);
            if (obs() !== want) begin bad++; $display("FAIL held_start_no_retrigger k=%0d cyc=%0d got=%b want=%b", k, cyc, obs(), want); end
            total++;
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            want = ev(1'b1, 1'b1, SH_HOLD, 4'd0, 1'b0);
            if (obs() !== want) begin bad++; $display("FAIL released_wait cyc=%0d got=%b want=%b", cyc, obs(), want); end
            total++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd1, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL second_start_load cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd1, 1'b1);
        if (obs() !== want) begin bad++; $display("FAIL second_start_anim cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
    endtask

    // Precondition: first ANIM cycle of screen 1 observed.
    task automatic test_reset_mid_anim();
        logic [8:0] want;
        for (int k = 0; k < 3; k++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                want = ev(1'b1, 1'b1, SH_HOLD, 4'd1, 1'b1);
                if (obs() !== want) begin bad++; $display("FAIL pre_reset_idle cyc=%0d got=%b want=%b", cyc, obs(), want); end
                total++;
            end
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            want = ev(1'b1, 1'b1, SH_LEFT, 4'd1, 1'b1);
            if (obs() !== want) begin bad++; $display("FAIL pre_reset_rotate k=%0d cyc=%0d got=%b want=%b", k, cyc, obs(), want); end
            total++;
        end
        rst = 1'b1;
        #1;
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd0, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL async_reset_immediate t=%0t got=%b want=%b", $time, obs(), want); end
        total++;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            want = ev(1'b1, 1'b1, SH_HOLD, 4'd0, 1'b0);
            if (obs() !== want) begin bad++; $display("FAIL async_reset_hold cyc=%0d got=%b want=%b", cyc, obs(), want); end
            total++;
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd0, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL post_reset_load cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd0, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL post_reset_wait cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        // a full-length animation afterwards shows the tick count restarted from zero
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd1, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL post_reset_start cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        run_anim(4'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd2, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL post_reset_level cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        want = ev(1'b0, 1'b1, SH_HOLD, 4'd2, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL plain_lose_clear cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b1, SH_HOLD, 4'd2, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL plain_lose_wait cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        want = ev(1'b1, 1'b0, SH_HOLD, 4'd0, 1'b0);
        if (obs() !== want) begin bad++; $display("FAIL plain_lose_restart cyc=%0d got=%b want=%b", cyc, obs(), want); end
        total++;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.SC_BackgSeq_start_InLow          = 1'b1;
        bus.SC_BackgSeq_levelcomplete_InHigh = 1'b0;
        bus.SC_BackgSeq_lose_InHigh          = 1'b0;
        bus.SC_BackgSeq_tick_InHigh          = 1'b0;
        test_reset();
        test_anim();
        test_lose_priority();
        test_win_path();
        test_start_held();
        test_reset_mid_anim();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
